// File: rtl/mem_arbiter.sv
// Two-master arbiter for a single-port synchronous-read memory bus.
// Master 0 (CPU) has fixed priority. A denied-cycle counter forces a grant
// to master 1 after MAX_WAIT losses, and a bounded lock lets master 1 keep
// the bus for up to MAX_LOCK consecutive cycles for atomic sequences.
//
// Handshake: a master asserts req together with addr/wdata/wren_n. The access
// happens in the cycle its gnt is high (gnt is combinational in that cycle).
// A denied master keeps req and its payload stable until gnt is seen. Read
// data appears on rdata one cycle after the grant, flagged by that master's
// rvalid. Writes never produce rvalid.
module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 3,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_wren_n,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_wren_n,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_wren_n,
    input  logic [DATA_W-1:0] mem_data_in
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int LOCK_W = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(MAX_LOCK - 1);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              lock_active_q, lock_active_d;
    logic              m0_rvalid_q, m0_rvalid_d;
    logic              m1_rvalid_q, m1_rvalid_d;
    logic              lock_extend;

    // Grant decision; gated by rst_n so nothing is granted while in reset.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst_n) begin
            if (lock_active_q && m1_req) begin
                m1_gnt = 1'b1;
            end else if (m1_req && (wait_cnt_q == WAIT_MAX)) begin
                m1_gnt = 1'b1;
            end else if (m0_req) begin
                m0_gnt = 1'b1;
            end else if (m1_req) begin
                m1_gnt = 1'b1;
            end
        end
    end

    // Bus mux: master 0 drives address/data by default, master 1 when granted.
    always_comb begin
        mem_address  = m0_addr;
        mem_data_out = m0_wdata;
        mem_wren_n   = 1'b1;
        if (m1_gnt) begin
            mem_address  = m1_addr;
            mem_data_out = m1_wdata;
            mem_wren_n   = m1_wren_n;
        end else if (m0_gnt) begin
            mem_wren_n   = m0_wren_n;
        end
    end

    // Next-state for the starvation counter, lock tracking and read valids.
    always_comb begin
        wait_cnt_d    = '0;
        lock_cnt_d    = '0;
        lock_active_d = 1'b0;
        m0_rvalid_d   = m0_gnt && m0_wren_n;
        m1_rvalid_d   = m1_gnt && m1_wren_n;

        if (m1_req && !m1_gnt) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q
                                                  : wait_cnt_q + WAIT_W'(1);
        end

        // The last permitted locked cycle (lock_cnt == MAX_LOCK-1) drops the
        // lock so master 0 gets at least one chance before master 1 returns.
        lock_extend = m1_gnt && m1_lock && (lock_cnt_q < LOCK_LAST);
        if (lock_extend) begin
            lock_active_d = 1'b1;
            lock_cnt_d    = lock_cnt_q + LOCK_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q    <= '0;
            lock_cnt_q    <= '0;
            lock_active_q <= 1'b0;
            m0_rvalid_q   <= 1'b0;
            m1_rvalid_q   <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            lock_cnt_q    <= lock_cnt_d;
            lock_active_q <= lock_active_d;
            m0_rvalid_q   <= m0_rvalid_d;
            m1_rvalid_q   <= m1_rvalid_d;
        end
    end

    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign rdata     = mem_data_in;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter for the CPU's single-port 16-bit memory bus (address / data_out / data_in / wren_n).
- Master 0 is the CPU. Master 1 is a secondary requester (DMA, program loader, debug port).
- Master 0 has fixed priority. A starvation counter guarantees master 1 service, and a bounded lock lets master 1 perform atomic multi-cycle sequences.
- Memory is synchronous-read: read data is valid one cycle after the address is presented.

Parameters:
- ADDR_W, 16, address width of the masters and the memory.
- DATA_W, 16, data width.
- MAX_WAIT, 3, denied contention cycles master 1 tolerates before being forced a grant.
- MAX_LOCK, 8, maximum consecutive cycles master 1 may hold the bus via m1_lock.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 access request for this cycle.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_wren_n  in  1  master 0 write enable, active low.
- m0_gnt  out  1  master 0 owns the bus this cycle.
- m0_rvalid  out  1  rdata holds master 0 read data.
- m1_req  in  1  master 1 request.
- m1_addr  in  ADDR_W  master 1 address.
- m1_wdata  in  DATA_W  master 1 write data.
- m1_wren_n  in  1  master 1 write enable, active low.
- m1_lock  in  1  master 1 requests to keep the grant next cycle.
- m1_gnt  out  1  master 1 owns the bus this cycle.
- m1_rvalid  out  1  rdata holds master 1 read data.
- rdata  out  DATA_W  shared read data, equal to mem_data_in.
- mem_address  out  ADDR_W  memory address.
- mem_data_out  out  DATA_W  memory write data.
- mem_wren_n  out  1  memory write enable, active low.
- mem_data_in  in  DATA_W  memory read data, valid one cycle after address.

Behaviour:
- Grants are combinational within the cycle, from the req inputs and the registered state (wait_cnt, lock_cnt, lock_active). At most one gnt is high per cycle.
- Arbitration order, first match wins:
  1. lock_active && m1_req -> m1_gnt.
  2. m1_req && wait_cnt == MAX_WAIT -> m1_gnt (forced).
  3. m0_req -> m0_gnt.
  4. m1_req -> m1_gnt.
  5. Otherwise no grant.
- Bus mux:
  - m0 granted, or no grant -> mem_address = m0_addr and mem_data_out = m0_wdata.
  - m1 granted -> mem_address = m1_addr and mem_data_out = m1_wdata.
  - mem_wren_n = granted master's wren_n; 1 when no grant.
- wait_cnt:
  - Increments by 1, saturating at MAX_WAIT, when m1_req && !m1_gnt.
  - Clears to 0 when m1_gnt or !m1_req.
- Lock:
  - lock_active is set next cycle when m1_gnt && m1_lock && lock_cnt < MAX_LOCK-1.
  - lock_cnt increments on each locked grant cycle.
  - lock_active and lock_cnt clear when m1_lock is low, m1_req is low, or the cap is reached.
  - After the cap, normal arbitration applies for at least one cycle. If m0_req is high that cycle, m0 is granted.
- Read-data valid:
  - m0_rvalid <= m0_gnt && m0_wren_n; m1_rvalid <= m1_gnt && m1_wren_n.
  - rvalid is registered, one-cycle latency. Writes never raise rvalid.
- Simultaneous requests:
  - m0 wins unless the lock or forced-wait rule applies.
  - A forced m1 grant lasts exactly one cycle unless m1_lock is high.
- A denied master must hold req, addr, wdata and wren_n stable until granted.
- Reset (async, any time):
  - gnt, rvalid, wait_cnt, lock_cnt and lock_active go to 0.
  - mem_wren_n = 1.
  - Any in-flight rvalid is dropped; no write is issued during reset.

Test Plan:
- Only m0_req=1, read at addr 0x0005 with mem_data_in=0xBEEF the next cycle -> m0_gnt=1, mem_address=0x0005, mem_wren_n=1; next cycle m0_rvalid=1, rdata=0xBEEF, m1_rvalid=0.
- m0_req and m1_req both held high continuously, MAX_WAIT=3 -> grant sequence m0,m0,m0,m1,m0,m0,m0,m1,...; wait_cnt never exceeds 3.
- m1 write 0x1234 to 0x0100 with m1_lock=1 and m0_req=1 throughout, MAX_LOCK=8 -> m1 holds the grant 8 consecutive cycles, then m0 is granted; mem_wren_n=0 only on m1 write cycles.
- m1 write (m1_wren_n=0) alone -> m1_gnt=1, mem_data_out=m1_wdata; m1_rvalid stays 0 on the next cycle.
- No requests -> both gnt=0, mem_wren_n=1, both rvalid=0 on the following cycle.
- rst_n pulled low during an m1 locked read -> outputs cleared immediately, with no clock edge required; after release, m0_req alone is granted on the first cycle.
